matmul_engine: RTL and testbench
================================

# matmul_engine

Hardwired, parametrised matrix-multiply engine that computes C = A × B directly out of the data RAM. It is the fixed-function successor to the instruction-driven 8-bit matrix core. It replaces the IROM, control unit and M/K/N loop registers with an internal FSM, programmable dimensions and base addresses, and a start/done handshake. It adds an accumulator that is wider than the data path, plus saturate or truncate write-back. It sits on the same DRAM port as the processor core.

## Interface
- WIDTH, 8: data word width, unsigned.
- ADDR_WIDTH, 8: DRAM address width.
- DIM_WIDTH, 4: width of each dimension; legal dimension range is 0..2^DIM_WIDTH-1.
- SATURATE, 0: 0 = write back the low WIDTH bits; 1 = clamp to 2^WIDTH-1.

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse or level; sampled only in IDLE.
- dimM, dimN, dimK  in  DIM_WIDTH each  A is M×N, B is N×K, C is M×K.
- baseA, baseB, baseC  in  ADDR_WIDTH each  row-major matrix base addresses.
- DRAM_addr  out  ADDR_WIDTH  memory address.
- DRAM_dataIn  in  WIDTH  read data, valid the cycle after memREAD.
- DRAM_dataOut  out  WIDTH  write data.
- memREAD, memWRITE  out  1  single-cycle strobes, never both high.
- busy  out  1  high while the computation runs.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky; set when any written C element exceeded WIDTH bits.

## Operation
- Element addresses, computed modulo 2^ADDR_WIDTH:
  - A[i][n] is at baseA + i·N + n.
  - B[n][j] is at baseB + n·K + j.
  - C[i][j] is at baseC + i·K + j.
- Addresses come from running pointers only; there are no multipliers in address generation.
  - aPtr advances by +1 per n and rewinds to the row start at the end of each j.
  - bPtr advances by +K per n and resets to baseB + j.
  - cPtr advances by +1 per write.
- Accumulator width is ACC = 2·WIDTH + DIM_WIDTH, unsigned, so it never wraps internally.
- Loop order: i outer, j middle, n inner.
- FSM states: IDLE, RD_A, RD_B, MAC, WR, DONE.
- IDLE:
  - If start=1 and M, N, K are all nonzero: latch the dimensions and bases, clear acc, clear overflow, go to RD_A.
  - If start=1 and any dimension is 0: go to DONE with no memory access; overflow is cleared.
- RD_A: memREAD=1, DRAM_addr=aPtr; go to RD_B.
- RD_B: memREAD=1, DRAM_addr=bPtr; capture DRAM_dataIn as a_reg; go to MAC.
- MAC: capture DRAM_dataIn as b, acc += a_reg·b.
  - If n < N-1: go to RD_A.
  - Else: go to WR.
- WR: memWRITE=1, DRAM_addr=cPtr, DRAM_dataOut = f(acc), then clear acc.
  - If acc > 2^WIDTH-1: set overflow.
  - If the last element was written: go to DONE.
  - Else: go to RD_A.
- Write-back function f(acc):
  - SATURATE=0: acc[WIDTH-1:0].
  - SATURATE=1: min(acc, 2^WIDTH-1).
- DONE: done=1; go to IDLE.
- start outside IDLE is ignored and has no side effects. Input ports are not re-sampled during a run.
- Outputs when not in RD_A, RD_B or WR: DRAM_addr=0, DRAM_dataOut=0, memREAD=0, memWRITE=0.

## Timing
- Reset value of every output is 0, and the state returns to IDLE.
- Reset mid-run aborts immediately:
  - No further strobes are issued.
  - acc, the counters and overflow are cleared.
  - done does not pulse.
- start accepted at edge e0: busy=1 from e0 through the final WR cycle.
- Cycles per C element = 3N + 1. Total busy cycles = M·K·(3N+1).
- done is high for exactly one cycle, starting at edge e0 + M·K·(3N+1); busy is 0 in that cycle.
- Zero-dimension start: done is high in the cycle after e0, and busy never rises.
- A new start is accepted in the cycle after DONE at the earliest.
- overflow is valid from the cycle after the offending WR. It holds until the next accepted start or reset.

## Test plan
- Basic 2×2×2 run:
  - Stimulus: M=N=K=2, A=[1,2,3,4] at 0x00, B=[5,6,7,8] at 0x10, baseC=0x20.
  - Response: writes 19, 22, 43, 50 to 0x20..0x23 in that order; done 28 cycles after start; overflow=0.
- Non-square shape with pointer wrap:
  - Stimulus: M=1, N=3, K=2, baseB=0xFE, B spanning 0xFE..0x03.
  - Response: B reads at 0xFE, 0x00, 0x02 for j=0; 6 reads and 1 write per element; done after 20 cycles.
- Width overflow:
  - Stimulus: M=N=K=1, A=16, B=16.
  - Response: SATURATE=0 writes 0x00, SATURATE=1 writes 0xFF; overflow=1 in both cases and held until the next start.
- Zero dimension:
  - Stimulus: dimN=0.
  - Response: no memREAD or memWRITE; busy stays 0; done pulses the cycle after start.
- start while busy:
  - Stimulus: start held high for an entire 2×2×2 run with different bases applied mid-run.
  - Response: results and addresses match the first configuration; a second run begins only after done.
- Reset mid-operation:
  - Stimulus: Rst_n low during the first MAC.
  - Response: all outputs 0 immediately; no write to C; done=0; after release a fresh start reproduces the basic 2×2×2 results exactly.

Source files
------------

// File: rtl/matmul_engine.sv
// Fixed-function C = A x B engine that streams operands from a shared single-port DRAM.
// One multiply-accumulate every three cycles; all addressing uses running pointers.
module matmul_engine #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DIM_WIDTH  = 4,
  parameter int unsigned SATURATE   = 0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  dimM,
  input  logic [DIM_WIDTH-1:0]  dimN,
  input  logic [DIM_WIDTH-1:0]  dimK,
  input  logic [ADDR_WIDTH-1:0] baseA,
  input  logic [ADDR_WIDTH-1:0] baseB,
  input  logic [ADDR_WIDTH-1:0] baseC,
  output logic [ADDR_WIDTH-1:0] DRAM_addr,
  input  logic [WIDTH-1:0]      DRAM_dataIn,
  output logic [WIDTH-1:0]      DRAM_dataOut,
  output logic                  memREAD,
  output logic                  memWRITE,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned ACC_W = 2 * WIDTH + DIM_WIDTH;
  localparam logic [ACC_W-1:0] ACC_MAX = {{(ACC_W - WIDTH){1'b0}}, {WIDTH{1'b1}}};

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR, DONE} state_e;

  state_e                state_q, state_d;
  logic [DIM_WIDTH-1:0]  m_q, m_d, n_q, n_d, k_q, k_d;
  logic [DIM_WIDTH-1:0]  i_q, i_d, j_q, j_d, nc_q, nc_d;
  logic [ADDR_WIDTH-1:0] a_ptr_q, a_ptr_d, a_row_q, a_row_d;
  logic [ADDR_WIDTH-1:0] b_ptr_q, b_ptr_d, b_col_q, b_col_d, b_base_q, b_base_d;
  logic [ADDR_WIDTH-1:0] c_ptr_q, c_ptr_d;
  logic [WIDTH-1:0]      a_reg_q, a_reg_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      dout_q, dout_d;
  logic                  rd_q, rd_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d;

  // Write-back: either keep the low bits or clamp to the largest word.
  function automatic logic [WIDTH-1:0] wb(input logic [ACC_W-1:0] v);
    if (SATURATE != 0 && v > ACC_MAX) return '1;
    return v[WIDTH-1:0];
  endfunction

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      nc_q     <= '0;
      a_ptr_q  <= '0;
      a_row_q  <= '0;
      b_ptr_q  <= '0;
      b_col_q  <= '0;
      b_base_q <= '0;
      c_ptr_q  <= '0;
      a_reg_q  <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      n_q      <= n_d;
      k_q      <= k_d;
      i_q      <= i_d;
      j_q      <= j_d;
      nc_q     <= nc_d;
      a_ptr_q  <= a_ptr_d;
      a_row_q  <= a_row_d;
      b_ptr_q  <= b_ptr_d;
      b_col_q  <= b_col_d;
      b_base_q <= b_base_d;
      c_ptr_q  <= c_ptr_d;
      a_reg_q  <= a_reg_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    n_d      = n_q;
    k_d      = k_q;
    i_d      = i_q;
    j_d      = j_q;
    nc_d     = nc_q;
    a_ptr_d  = a_ptr_q;
    a_row_d  = a_row_q;
    b_ptr_d  = b_ptr_q;
    b_col_d  = b_col_q;
    b_base_d = b_base_q;
    c_ptr_d  = c_ptr_q;
    a_reg_d  = a_reg_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    addr_d   = '0;
    dout_d   = '0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (dimM != '0 && dimN != '0 && dimK != '0) begin
            m_d      = dimM;
            n_d      = dimN;
            k_d      = dimK;
            i_d      = '0;
            j_d      = '0;
            nc_d     = '0;
            a_ptr_d  = baseA;
            a_row_d  = baseA;
            b_ptr_d  = baseB;
            b_col_d  = baseB;
            b_base_d = baseB;
            c_ptr_d  = baseC;
            acc_d    = '0;
            state_d  = RD_A;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        a_reg_d = DRAM_dataIn;
        state_d = MAC;
      end
      MAC: begin
        acc_d   = acc_q + ACC_W'(a_reg_q) * ACC_W'(DRAM_dataIn);
        a_ptr_d = a_ptr_q + ADDR_WIDTH'(1);
        b_ptr_d = b_ptr_q + ADDR_WIDTH'(k_q);
        if (nc_q != n_q - DIM_WIDTH'(1)) begin
          nc_d    = nc_q + DIM_WIDTH'(1);
          state_d = RD_A;
        end else begin
          state_d = WR;
        end
      end
      WR: begin
        acc_d   = '0;
        nc_d    = '0;
        c_ptr_d = c_ptr_q + ADDR_WIDTH'(1);
        if (acc_q > ACC_MAX) ovf_d = 1'b1;
        // End of a row of C: A pointer already sits on the next row, B restarts at column 0.
        if (j_q == k_q - DIM_WIDTH'(1)) begin
          j_d     = '0;
          a_row_d = a_ptr_q;
          b_col_d = b_base_q;
          b_ptr_d = b_base_q;
          if (i_q == m_q - DIM_WIDTH'(1)) begin
            state_d = DONE;
          end else begin
            i_d     = i_q + DIM_WIDTH'(1);
            state_d = RD_A;
          end
        end else begin
          j_d     = j_q + DIM_WIDTH'(1);
          a_ptr_d = a_row_q;
          b_col_d = b_col_q + ADDR_WIDTH'(1);
          b_ptr_d = b_col_q + ADDR_WIDTH'(1);
          state_d = RD_A;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered: load them with the values the upcoming state presents.
    case (state_d)
      RD_A: begin
        rd_d   = 1'b1;
        addr_d = a_ptr_d;
      end
      RD_B: begin
        rd_d   = 1'b1;
        addr_d = b_ptr_d;
      end
      WR: begin
        wr_d   = 1'b1;
        addr_d = c_ptr_d;
        dout_d = wb(acc_d);
      end
      default: ;
    endcase
    busy_d = (state_d == RD_A) || (state_d == RD_B) || (state_d == MAC) || (state_d == WR);
    done_d = (state_d == DONE);
  end

  assign DRAM_addr    = addr_q;
  assign DRAM_dataOut = dout_q;
  assign memREAD      = rd_q;
  assign memWRITE     = wr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Bench for matmul_engine: directed table, start-hold and reset-abort sequences, then
// randomized runs against a plain-arithmetic matrix model; truncate and saturate DUTs in lockstep.
module tb_matmul_engine;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 4;

  logic          Clk = 1'b0;
  logic          Rst_n, start, clr;
  logic [DW-1:0] dimM, dimN, dimK;
  logic [AW-1:0] baseA, baseB, baseC;
  logic [W-1:0]  dram_in;
  logic [AW-1:0] addr, s_addr;
  logic [W-1:0]  dout, s_dout;
  logic          rd, wr, busy, done, ovf;
  logic          s_rd, s_wr, s_busy, s_done, s_ovf;

  always #5 Clk = ~Clk;

  matmul_engine #(.WIDTH(W), .ADDR_WIDTH(AW), .DIM_WIDTH(DW), .SATURATE(0)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .start(start),
    .dimM(dimM), .dimN(dimN), .dimK(dimK),
    .baseA(baseA), .baseB(baseB), .baseC(baseC),
    .DRAM_addr(addr), .DRAM_dataIn(dram_in), .DRAM_dataOut(dout),
    .memREAD(rd), .memWRITE(wr), .busy(busy), .done(done), .overflow(ovf)
  );

  matmul_engine #(.WIDTH(W), .ADDR_WIDTH(AW), .DIM_WIDTH(DW), .SATURATE(1)) u_sat (
    .Clk(Clk), .Rst_n(Rst_n), .start(start),
    .dimM(dimM), .dimN(dimN), .dimK(dimK),
    .baseA(baseA), .baseB(baseB), .baseC(baseC),
    .DRAM_addr(s_addr), .DRAM_dataIn(dram_in), .DRAM_dataOut(s_dout),
    .memREAD(s_rd), .memWRITE(s_wr), .busy(s_busy), .done(s_done), .overflow(s_ovf)
  );

  logic [7:0] mem [256];
  int rd_log[$], wa_log[$], wd_log[$], ws_log[$];
  int lock_errs = 0;
  int vectors = 0;
  int errors  = 0;

  // DRAM model: read data appears the cycle after the strobe; writes are logged only.
  always @(posedge Clk) begin
    if (clr) begin
      rd_log.delete();
      wa_log.delete();
      wd_log.delete();
      ws_log.delete();
    end
    if (rd) begin
      dram_in <= mem[addr];
      rd_log.push_back(int'(addr));
    end
    if (wr) begin
      wa_log.push_back(int'(addr));
      wd_log.push_back(int'(dout));
    end
    if (s_wr) ws_log.push_back(int'(s_dout));
  end

  // Address and control of the saturating instance must track the truncating one.
  always @(negedge Clk)
    if ({s_addr, s_rd, s_wr, s_busy, s_done} !== {addr, rd, wr, busy, done})
      lock_errs <= lock_errs + 1;

  typedef struct {
    int          m, n, k;
    logic [7:0]  ba, bb, bc;
    logic [31:0] a_dat;   // byte x = A element x (row-major)
    logic [47:0] b_dat;   // byte x = B element x (row-major)
    int          cyc;
    int          c_cnt;
    logic [31:0] c_trunc; // byte x = x-th C write, truncating
    logic [31:0] c_sat;
    bit          ovf;
  } vec_t;

  int exp_rd[$], exp_wa[$], exp_wd[$], exp_ws[$];
  int exp_cyc, obs_cyc;
  bit exp_ovf, busy_bad, busy_at_done, post_done, post_busy;
  int lock_delta;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic chk_q(input string nm, input int act[$], input int exp[$]);
    int bad;
    bad = -1;
    vectors++;
    if (act.size() != exp.size()) begin
      errors++;
      $display("FAIL %s: %0d entries, required %0d", nm, act.size(), exp.size());
    end else begin
      foreach (exp[x]) if (bad < 0 && act[x] != exp[x]) bad = x;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s[%0d]: got 0x%0h, required 0x%0h", nm, bad, act[bad], exp[bad]);
      end
    end
  endtask

  // Reference: C[i][j] = sum_n A[i][n]*B[n][j], addresses wrap at 256.
  task automatic build_model(input int m, n, k, input logic [7:0] ba, bb, bc);
    logic [7:0] aa, bx, ca;
    int sum;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete(); exp_ws.delete();
    exp_ovf = 1'b0;
    exp_cyc = (m == 0 || n == 0 || k == 0) ? 0 : m * k * (3 * n + 1);
    if (exp_cyc == 0) return;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < k; j++) begin
        sum = 0;
        for (int x = 0; x < n; x++) begin
          aa = ba + 8'(i * n + x);
          bx = bb + 8'(x * k + j);
          exp_rd.push_back(int'(aa));
          exp_rd.push_back(int'(bx));
          sum += int'(mem[aa]) * int'(mem[bx]);
        end
        ca = bc + 8'(i * k + j);
        exp_wa.push_back(int'(ca));
        exp_wd.push_back(sum % 256);
        exp_ws.push_back(sum > 255 ? 255 : sum);
        if (sum > 255) exp_ovf = 1'b1;
      end
  endtask

  task automatic do_run(input int m, n, k, input logic [7:0] ba, bb, bc, input bit hold);
    int lock0;
    build_model(m, n, k, ba, bb, bc);
    @(negedge Clk);
    dimM = DW'(m); dimN = DW'(n); dimK = DW'(k);
    baseA = ba; baseB = bb; baseC = bc;
    start = 1'b1;
    clr = 1'b1;
    @(posedge Clk);
    lock0 = lock_errs;
    obs_cyc = 9999;
    busy_bad = 1'b0;
    busy_at_done = 1'b1;
    for (int c = 0; c < exp_cyc + 20; c++) begin
      @(negedge Clk);
      clr = 1'b0;
      if (!hold) start = 1'b0;
      if (hold && c == 5) begin
        dimM = 4'd3; dimN = 4'd3; dimK = 4'd3;
        baseA = 8'h90; baseB = 8'hA0; baseC = 8'hB0;
      end
      if (done === 1'b1) begin
        obs_cyc = c;
        busy_at_done = busy;
        break;
      end
      if (busy !== 1'b1) busy_bad = 1'b1;
    end
    @(negedge Clk);
    post_done = done;
    post_busy = busy;
    lock_delta = lock_errs - lock0;
  endtask

  task automatic check_run(input string nm);
    chk({nm, " done cycle"}, obs_cyc, exp_cyc);
    chk({nm, " busy during run"}, busy_bad, 0);
    chk({nm, " busy in done cycle"}, busy_at_done, 0);
    chk({nm, " done single pulse"}, post_done, 0);
    chk({nm, " busy after done"}, post_busy, 0);
    chk_q({nm, " read addrs"}, rd_log, exp_rd);
    chk_q({nm, " write addrs"}, wa_log, exp_wa);
    chk_q({nm, " write data"}, wd_log, exp_wd);
    chk_q({nm, " sat write data"}, ws_log, exp_ws);
    chk({nm, " overflow"}, ovf, exp_ovf);
    chk({nm, " sat overflow"}, s_ovf, exp_ovf);
    chk({nm, " lockstep"}, lock_delta, 0);
  endtask

  task automatic load_vec(input vec_t t);
    for (int x = 0; x < 4; x++) mem[t.ba + 8'(x)] = t.a_dat[8*x +: 8];
    for (int x = 0; x < 6; x++) mem[t.bb + 8'(x)] = t.b_dat[8*x +: 8];
  endtask

  task automatic chk_bytes(input string nm, input int q[$], input logic [31:0] exp, input int cnt);
    chk({nm, " write count"}, q.size(), cnt);
    for (int x = 0; x < cnt; x++)
      chk($sformatf("%s C%0d", nm, x), q[x], exp[8*x +: 8]);
  endtask

  vec_t tbl [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{m:2, n:2, k:2, ba:8'h00, bb:8'h10, bc:8'h20, a_dat:32'h04030201,
               b_dat:48'h08070605, cyc:28, c_cnt:4, c_trunc:32'h322B1613,
               c_sat:32'h322B1613, ovf:1'b0};
    tbl[1] = '{m:1, n:3, k:2, ba:8'h40, bb:8'hFE, bc:8'h80, a_dat:32'h00030201,
               b_dat:48'h060504030201, cyc:20, c_cnt:2, c_trunc:32'h00001C16,
               c_sat:32'h00001C16, ovf:1'b0};
    tbl[2] = '{m:1, n:1, k:1, ba:8'h50, bb:8'h60, bc:8'h70, a_dat:32'h00000010,
               b_dat:48'h000000000010, cyc:4, c_cnt:1, c_trunc:32'h00000000,
               c_sat:32'h000000FF, ovf:1'b1};
    tbl[3] = '{m:2, n:0, k:2, ba:8'h00, bb:8'h10, bc:8'h20, a_dat:32'h04030201,
               b_dat:48'h08070605, cyc:0, c_cnt:0, c_trunc:32'h0,
               c_sat:32'h0, ovf:1'b0};

    Rst_n = 1'b0; start = 1'b0; clr = 1'b0;
    dimM = '0; dimN = '0; dimK = '0;
    baseA = '0; baseB = '0; baseC = '0;
    for (int x = 0; x < 256; x++) mem[x] = 8'h00;
    repeat (3) @(negedge Clk);
    chk("reset outputs", {addr, dout, rd, wr, busy, done, ovf}, 0);
    Rst_n = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 4; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      repeat (3) @(negedge Clk);
      if (i > 0) chk({nm, " overflow held"}, ovf, tbl[i-1].ovf);
      load_vec(tbl[i]);
      do_run(tbl[i].m, tbl[i].n, tbl[i].k, tbl[i].ba, tbl[i].bb, tbl[i].bc, 1'b0);
      check_run(nm);
      chk({nm, " cycles"}, obs_cyc, tbl[i].cyc);
      chk({nm, " reads"}, rd_log.size(), 2 * tbl[i].m * tbl[i].n * tbl[i].k);
      chk_bytes(nm, wd_log, tbl[i].c_trunc, tbl[i].c_cnt);
      chk_bytes({nm, " sat"}, ws_log, tbl[i].c_sat, tbl[i].c_cnt);
      chk({nm, " table overflow"}, ovf, tbl[i].ovf);
      if (i == 1)
        chk("wrap j0 B reads", (rd_log[1] << 16) | (rd_log[3] << 8) | rd_log[5], 64'h00FE0002);
    end

    // start held through a whole run while the configuration changes underneath
    load_vec(tbl[0]);
    do_run(2, 2, 2, 8'h00, 8'h10, 8'h20, 1'b1);
    check_run("hold");
    chk_bytes("hold", wd_log, tbl[0].c_trunc, 4);
    @(negedge Clk);
    chk("hold restart after done", busy, 1);
    start = 1'b0;
    Rst_n = 1'b0;
    #1;
    chk("hold reset outputs", {addr, dout, rd, wr, busy, done, ovf}, 0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // reset during the first MAC
    load_vec(tbl[0]);
    @(negedge Clk);
    dimM = 4'd2; dimN = 4'd2; dimK = 4'd2;
    baseA = 8'h00; baseB = 8'h10; baseC = 8'h20;
    start = 1'b1; clr = 1'b1;
    @(posedge Clk);
    @(negedge Clk); start = 1'b0; clr = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("busy before abort", busy, 1);
    Rst_n = 1'b0;
    #1;
    chk("abort outputs", {addr, dout, rd, wr, busy, done, ovf, s_busy, s_ovf}, 0);
    begin
      bit seen;
      seen = 1'b0;
      repeat (3) begin
        @(negedge Clk);
        if (done !== 1'b0 || rd !== 1'b0 || wr !== 1'b0) seen = 1'b1;
      end
      Rst_n = 1'b1;
      repeat (2) begin
        @(negedge Clk);
        if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      chk("abort quiet", seen, 0);
      chk("abort no C write", wa_log.size(), 0);
    end
    do_run(2, 2, 2, 8'h00, 8'h10, 8'h20, 1'b0);
    check_run("after abort");
    chk_bytes("after abort", wd_log, tbl[0].c_trunc, 4);

    for (int r = 0; r < 10; r++) begin
      int m, n, k, lim;
      logic [7:0] ba, bb, bc;
      m = $urandom_range(1, 5);
      n = $urandom_range(1, 5);
      k = $urandom_range(1, 5);
      if (r == 0) begin m = 15; n = 2; k = 1; end
      if (r == 1) begin m = 1; n = 2; k = 15; end
      if ($urandom_range(0, 7) == 0) k = 0;
      lim = ($urandom_range(0, 1) == 1) ? 255 : 7;
      ba = 8'($urandom_range(0, 40));
      bb = 8'($urandom_range(80, 120));
      bc = 8'($urandom_range(160, 230));
      for (int x = 0; x < m * n; x++) mem[ba + 8'(x)] = 8'($urandom_range(0, lim));
      for (int x = 0; x < n * k; x++) mem[bb + 8'(x)] = 8'($urandom_range(0, lim));
      do_run(m, n, k, ba, bb, bc, 1'b0);
      check_run($sformatf("rnd%0d(%0dx%0dx%0d)", r, m, n, k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
